// File: rtl/tpu_a_skew_feeder.sv
// tpu_a_skew_feeder: holds a DIM x DIM signed A tile and streams it diagonally skewed into the array; optional a_valid via TPU_FEEDER_VALID_EN
module tpu_a_skew_feeder #(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     wr_en,
  input  logic [$clog2(DIM)-1:0]   wr_row,
  input  logic [DIM*BITS_AB-1:0]   wr_data,
  input  logic                     start,
  output logic [DIM*BITS_AB-1:0]   a_out,
  output logic                     busy,
  output logic                     done
`ifdef TPU_FEEDER_VALID_EN
  ,
  output logic [DIM-1:0]           a_valid
`endif
);
  localparam int AW = $clog2(DIM);
  localparam int KW = $clog2(2*DIM);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]               state_q, state_d;
  logic [KW-1:0]            k_q, k_d, k_nx;
  logic [DIM*BITS_AB-1:0]   a_out_q, a_out_d, lane_pack;
  logic [BITS_AB-1:0]       mem_q [DIM][DIM];
  logic [BITS_AB-1:0]       mem_d [DIM][DIM];
  logic [DIM-1:0]           hit;
  logic                     last;

  assign k_nx = k_q + 1'b1;

  for (genvar i = 0; i < DIM; i++) begin : g_lane
    logic signed [31:0] col;
    assign col    = int'(k_nx) - 1 - i;
    assign hit[i] = col >= 0 && col < DIM;
    assign lane_pack[i*BITS_AB +: BITS_AB] = hit[i] ? mem_q[i][AW'(col)] : '0;
  end

  // Tile memory accepts row writes only while idle; out-of-range rows are dropped
  always_comb begin
    mem_d = mem_q;
    if (state_q == S_IDLE && wr_en && int'(wr_row) < DIM)
      for (int j = 0; j < DIM; j++) mem_d[wr_row][j] = wr_data[j*BITS_AB +: BITS_AB];
  end

  // Sequencer: IDLE -> STREAM (2*DIM-1 enabled edges) -> DONE -> IDLE, lane loads follow k
  always_comb begin
    last    = k_q == KW'(2*DIM-1);
    state_d = state_q;
    k_d     = k_q;
    a_out_d = '0;
    case (state_q)
      S_IDLE: begin
        k_d = '0;
        if (en && start && !wr_en) state_d = S_STREAM;
      end
      S_STREAM: begin
        if (!en) a_out_d = a_out_q;
        else if (last) state_d = S_DONE;
        else begin
          k_d     = k_nx;
          a_out_d = lane_pack;
        end
      end
      default: begin
        state_d = S_IDLE;
        k_d     = '0;
      end
    endcase
  end

  // State, counter, output lanes and tile memory
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      a_out_q <= '0;
      mem_q   <= '{default: '{default: '0}};
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_out_q <= a_out_d;
      mem_q   <= mem_d;
    end
  end

  assign a_out = a_out_q;
  assign busy  = state_q != S_IDLE;
  assign done  = state_q == S_DONE;

`ifdef TPU_FEEDER_VALID_EN
  logic [DIM-1:0] a_valid_q, a_valid_d;

  // Lane valid flags track which lanes carry tile elements, same timing as a_out
  always_comb begin
    a_valid_d = '0;
    if (state_q == S_STREAM) a_valid_d = !en ? a_valid_q : (last ? '0 : hit);
  end

  // Valid register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) a_valid_q <= '0;
    else a_valid_q <= a_valid_d;
  end

  assign a_valid = a_valid_q;
`endif
endmodule
